// File: rtl/ram_rd_streamer_pkg.sv
// Shared constants and state encodings for the RAM read streamer.
// RDLAT must match the read latency of the attached sync RAM.
package ram_rd_streamer_pkg;

  localparam int RDLAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Fall-through output FIFO with registered storage.
// The occupancy count feeds the streamer's credit check.
module ram_rd_fifo #(
  parameter int W = 9,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [W-1:0]       wr_data,
  input  logic               rd_en,
  output logic [W-1:0]       rd_data,
  output logic               valid,
  output logic [$clog2(D):0] count
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign valid   = (count != '0);
  assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ram_rd_streamer.sv
// Read-side master for a 2-cycle sync RAM: issues addresses
// under FIFO credit and streams words to a valid/ready sink.
module ram_rd_streamer
  import ram_rd_streamer_pkg::*;
#(
  parameter int ADDRBIT   = 6,
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 8,
  parameter int FIFODEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDRBIT-1:0] cmd_addr,
  input  logic [ADDRBIT:0]   cmd_len,
  output logic [ADDRBIT-1:0] rdaddress,
  input  logic [WIDTH-1:0]   q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               done,
  output logic               busy
);

  localparam int CW = $clog2(FIFODEPTH + RDLAT) + 1;
  localparam int FW = $clog2(FIFODEPTH) + 1;

  state_t             state;
  logic [ADDRBIT:0]   remaining;
  logic [RDLAT-1:0]   tag_vld;
  logic [RDLAT-1:0]   tag_lst;
  logic [CW-1:0]      inflight;
  logic [FW-1:0]      fifo_count;
  logic [WIDTH:0]     fifo_out;
  logic [ADDRBIT-1:0] addr_nxt;
  logic               issue;
  logic               pop;
  logic               fin;
  logic               last_issue;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) begin
      inflight = inflight + CW'(tag_vld[i]);
    end
  end

  // Every issued read owns a FIFO slot, so a write never finds it full.
  assign issue = (state == ST_RUN) &&
                 (inflight + CW'(fifo_count) < CW'(FIFODEPTH));

  assign last_issue = issue && (remaining == (ADDRBIT+1)'(1));
  assign pop        = out_valid && out_ready;
  assign fin        = pop && out_last;

  assign addr_nxt = (rdaddress == ADDRBIT'(DEPTH-1)) ?
                    '0 : rdaddress + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rdaddress <= '0;
      remaining <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= ST_RUN;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              rdaddress <= cmd_addr;
              remaining <= cmd_len;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            rdaddress <= addr_nxt;
            remaining <= remaining - 1'b1;
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fin) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_lst <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_lst[0] <= last_issue;
      for (int i = 1; i < RDLAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_lst[i] <= tag_lst[i-1];
      end
    end
  end

  ram_rd_fifo #(
    .W(WIDTH+1),
    .D(FIFODEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (tag_vld[RDLAT-1]),
    .wr_data({tag_lst[RDLAT-1], q}),
    .rd_en  (pop),
    .rd_data(fifo_out),
    .valid  (out_valid),
    .count  (fifo_count)
  );

  assign out_data = fifo_out[WIDTH-1:0];
  assign out_last = fifo_out[WIDTH];

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Bench for ram_rd_streamer paired with a 2-cycle RAM model
// holding mem[i]=i; expected streams come from address arithmetic.
module tb_ram_rd_streamer;

  localparam int ADDRBIT   = 6;
  localparam int DEPTH     = 64;
  localparam int WIDTH     = 8;
  localparam int FIFODEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [ADDRBIT-1:0] cmd_addr = '0;
  logic [ADDRBIT:0]   cmd_len = '0;
  logic [ADDRBIT-1:0] rdaddress;
  logic [WIDTH-1:0]   q;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               done;
  logic               busy;

  always #5 clk = ~clk;

  ram_rd_streamer #(
    .ADDRBIT  (ADDRBIT),
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .FIFODEPTH(FIFODEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .rdaddress(rdaddress),
    .q        (q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done),
    .busy     (busy)
  );

  // RAM model: registered read address, registered data out.
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDRBIT-1:0] ram_ra = '0;
  always @(posedge clk) begin
    ram_ra <= rdaddress;
    q      <= mem[ram_ra];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int max_cnt = 0;
  bit wrap_seen = 0;
  logic [ADDRBIT-1:0] prev_ra = '0;

  logic [WIDTH-1:0] rx_d [$];
  logic             rx_l [$];
  int               rx_c [$];

  logic             pv, pr, pl, prst;
  logic [WIDTH-1:0] pd;

  always @(posedge clk) begin
    cyc++;
    pv   = out_valid;
    pr   = out_ready;
    pd   = out_data;
    pl   = out_last;
    prst = rst_n;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_ra == ADDRBIT'(DEPTH-1) && rdaddress == '0)
      wrap_seen = 1;
    prev_ra = rdaddress;
    if (int'(dut.u_fifo.count) > max_cnt)
      max_cnt = int'(dut.u_fifo.count);
    if (prst && rst_n && pv && !pr) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== pd ||
          out_last !== pl) begin
        errors++;
        $display("FAIL hold: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                 out_valid, out_data, out_last, pd, pl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input int a, input int l);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_wait: got cmd_ready=0 want 1");
    end
    assert (a < DEPTH && l <= DEPTH)
      else $error("command out of contract");
    done_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_addr  = ADDRBIT'(a);
    cmd_len   = (ADDRBIT+1)'(l);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  // mode 0: ready high, 1: toggle, 2: random
  task automatic collect(input int n, input int mode, input int maxc);
    int c = 0;
    rx_d.delete();
    rx_l.delete();
    rx_c.delete();
    while (rx_d.size() < n && c < maxc) begin
      @(negedge clk);
      c++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 1);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid && out_ready) begin
        rx_d.push_back(out_data);
        rx_l.push_back(out_last);
        rx_c.push_back(cyc);
      end
    end
  endtask

  task automatic idle(input int n, output int vcnt);
    vcnt = 0;
    out_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (cmd_ready !== 1'b1 || rdaddress !== '0 ||
        out_valid !== 1'b0 || out_data !== '0 ||
        out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b ra=%0d v=%b d=%0d l=%b dn=%b b=%b",
               cmd_ready, rdaddress, out_valid, out_data,
               out_last, done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b v=%b want 1 0",
               cmd_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int v;
    out_ready = 1'b1;
    send_cmd(5, 4);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy: got b=%b rdy=%b want 1 0", busy, cmd_ready);
    end
    collect(4, 0, 40);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= rx_d.size() || rx_d[k] !== WIDTH'(5 + k) ||
          rx_l[k] !== (k == 3)) begin
        errors++;
        $display("FAIL basic_w%0d: got %0d/%0d want %0d",
                 k, (k < rx_d.size()) ? rx_d[k] : 0,
                 (k < rx_l.size()) ? rx_l[k] : 0, 5 + k);
      end
    end
    if (rx_c.size() == 4) begin
      checks++;
      if (rx_c[0] - acc_cyc != 3) begin
        errors++;
        $display("FAIL latency: got %0d want 3", rx_c[0] - acc_cyc);
      end
      checks++;
      if (rx_c[3] - rx_c[0] != 3) begin
        errors++;
        $display("FAIL throughput: got %0d want 3", rx_c[3] - rx_c[0]);
      end
    end
    idle(6, v);
    checks++;
    if (done_cnt != 1 || (rx_c.size() == 4 && done_cyc != rx_c[3] + 1)) begin
      errors++;
      $display("FAIL basic_done: got cnt=%0d cyc=%0d want 1", done_cnt,
               done_cyc);
    end
    checks++;
    if (v != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: got v=%0d b=%b rdy=%b want 0 0 1",
               v, busy, cmd_ready);
    end
  endtask

  task automatic test_wrap();
    int v;
    wrap_seen = 0;
    send_cmd(62, 4);
    collect(4, 0, 40);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= rx_d.size() || rx_d[k] !== WIDTH'((62 + k) % DEPTH) ||
          rx_l[k] !== (k == 3)) begin
        errors++;
        $display("FAIL wrap_w%0d: got %0d want %0d", k,
                 (k < rx_d.size()) ? rx_d[k] : 0, (62 + k) % DEPTH);
      end
    end
    idle(4, v);
    checks++;
    if (!wrap_seen || rdaddress !== ADDRBIT'(2)) begin
      errors++;
      $display("FAIL wrap_addr: got seen=%0d ra=%0d want 1 2",
               wrap_seen, rdaddress);
    end
  endtask

  task automatic test_toggle();
    int v;
    max_cnt = 0;
    send_cmd(0, 16);
    collect(16, 1, 200);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (k >= rx_d.size() || rx_d[k] !== WIDTH'(k) ||
          rx_l[k] !== (k == 15)) begin
        errors++;
        $display("FAIL toggle_w%0d: got %0d want %0d", k,
                 (k < rx_d.size()) ? rx_d[k] : 0, k);
      end
    end
    idle(6, v);
    checks++;
    if (v != 0 || max_cnt > FIFODEPTH || done_cnt != 1) begin
      errors++;
      $display("FAIL toggle_tail: got v=%0d max=%0d dn=%0d want 0 <=4 1",
               v, max_cnt, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int v;
    out_ready = 1'b0;
    send_cmd(10, 8);
    repeat (20) @(negedge clk);
    checks++;
    if (rdaddress !== ADDRBIT'(14) || out_valid !== 1'b1 ||
        out_data !== WIDTH'(10)) begin
      errors++;
      $display("FAIL stall: got ra=%0d v=%b d=%0d want 14 1 10",
               rdaddress, out_valid, out_data);
    end
    collect(8, 0, 60);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= rx_d.size() || rx_d[k] !== WIDTH'(10 + k) ||
          rx_l[k] !== (k == 7)) begin
        errors++;
        $display("FAIL bp_w%0d: got %0d want %0d", k,
                 (k < rx_d.size()) ? rx_d[k] : 0, 10 + k);
      end
    end
    idle(6, v);
    checks++;
    if (v != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_tail: got v=%0d dn=%0d want 0 1", v, done_cnt);
    end
  endtask

  task automatic test_zero_len();
    int v;
    logic [ADDRBIT-1:0] ra0;
    ra0 = rdaddress;
    send_cmd(7, 0);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got dn=%b rdy=%b b=%b want 1 1 0",
               done, cmd_ready, busy);
    end
    idle(6, v);
    checks++;
    if (v != 0 || rdaddress !== ra0 || done_cnt != 1 ||
        cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_idle: got v=%0d ra=%0d dn=%0d want 0 %0d 1",
               v, rdaddress, done_cnt, ra0);
    end
  endtask

  task automatic test_reset_mid();
    int v;
    send_cmd(40, 8);
    collect(3, 0, 40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rdaddress !== '0 ||
        out_valid !== 1'b0 || out_data !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b ra=%0d v=%b d=%0d b=%b",
               cmd_ready, rdaddress, out_valid, out_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(20, 2);
    collect(2, 0, 40);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= rx_d.size() || rx_d[k] !== WIDTH'(20 + k) ||
          rx_l[k] !== (k == 1)) begin
        errors++;
        $display("FAIL mid_w%0d: got %0d want %0d", k,
                 (k < rx_d.size()) ? rx_d[k] : 0, 20 + k);
      end
    end
    idle(10, v);
    checks++;
    if (v != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_tail: got v=%0d dn=%0d want 0 1", v, done_cnt);
    end
  endtask

  task automatic test_random();
    int a, l, v;
    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 24);
      send_cmd(a, l);
      collect(l, 2, 400);
      checks++;
      if (rx_d.size() != l) begin
        errors++;
        $display("FAIL rnd%0d_len: got %0d want %0d", it, rx_d.size(), l);
      end
      for (int k = 0; k < rx_d.size(); k++) begin
        checks++;
        if (rx_d[k] !== WIDTH'((a + k) % DEPTH) ||
            rx_l[k] !== (k == l - 1)) begin
          errors++;
          $display("FAIL rnd%0d_w%0d: got %0d/%0d want %0d", it, k,
                   rx_d[k], rx_l[k], (a + k) % DEPTH);
        end
      end
      idle(5, v);
      checks++;
      if (v != 0 || done_cnt != 1) begin
        errors++;
        $display("FAIL rnd%0d_tail: got v=%0d dn=%0d want 0 1",
                 it, v, done_cnt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_toggle();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
